// File: rtl/note_recorder_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | note_recorder_pkg: FSM states, octave/duration classes, melody code table |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
package note_recorder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_HOLD  = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    OCT_MID  = 2'd0,
    OCT_LOW  = 2'd1,
    OCT_HIGH = 2'd2
  } octave_t;

  typedef enum logic [1:0] {
    DUR_8TH  = 2'd0,
    DUR_4TH  = 2'd1,
    DUR_16TH = 2'd2
  } dur_t;

  localparam logic [5:0] REST = 6'd0;

  localparam logic [5:0] BASE_MID_8TH  = 6'd0;
  localparam logic [5:0] BASE_MID_4TH  = 6'd7;
  localparam logic [5:0] BASE_MID_16TH = 6'd14;
  localparam logic [5:0] BASE_LOW_8TH  = 6'd21;
  localparam logic [5:0] BASE_LOW_4TH  = 6'd28;
  localparam logic [5:0] BASE_LOW_16TH = 6'd35;
  localparam logic [5:0] BASE_HI_8TH   = 6'd42;
  localparam logic [5:0] BASE_HI_4TH   = 6'd49;
  localparam logic [5:0] BASE_HI_16TH  = 6'd56;

  function automatic logic [5:0] code_base(input octave_t oct, input dur_t dur);
    logic [5:0] b;
    b = BASE_MID_8TH;
    case (oct)
      OCT_LOW:  b = (dur == DUR_4TH) ? BASE_LOW_4TH : (dur == DUR_16TH) ? BASE_LOW_16TH : BASE_LOW_8TH;
      OCT_HIGH: b = (dur == DUR_4TH) ? BASE_HI_4TH  : (dur == DUR_16TH) ? BASE_HI_16TH  : BASE_HI_8TH;
      default:  b = (dur == DUR_4TH) ? BASE_MID_4TH : (dur == DUR_16TH) ? BASE_MID_16TH : BASE_MID_8TH;
    endcase
    return b;
  endfunction

  // Highest set key bit is the lowest note; do (bit 6) maps to 1, si (bit 0) to 7.
  function automatic logic [2:0] key_to_note(input logic [6:0] k);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < 7; i++) begin
      if (k[i]) n = 3'(7 - i);
    end
    return n;
  endfunction

  function automatic octave_t sel_octave(input logic hi, input logic lo);
    octave_t o;
    o = OCT_MID;
    if (hi && !lo) o = OCT_HIGH;
    else if (lo && !hi) o = OCT_LOW;
    return o;
  endfunction

endpackage
`default_nettype wire

// File: rtl/note_recorder_encoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | note_encoder: (note index, octave, duration class) -> 6-bit melody code   |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module note_encoder
  import note_recorder_pkg::*;
(
  input  logic [2:0] note,
  input  octave_t    octave,
  input  dur_t       dur,
  output logic [5:0] code
);

  assign code = code_base(octave, dur) + {3'b000, note};

endmodule
`default_nettype wire

// File: rtl/note_recorder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | note_recorder: turns key presses and gaps into a buffered melody stream   |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module note_recorder
  import note_recorder_pkg::*;
#(
  parameter int TICK_16   = 12_500_000,
  parameter int MAX_NOTES = 64,
  parameter int LEN_W     = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rec_en,
  input  logic [6:0]       keys,
  input  logic             is_high,
  input  logic             is_low,
  input  logic [LEN_W-1:0] rd_idx,
  output logic [5:0]       rd_code,
  output logic             code_vld,
  output logic [5:0]       code_out,
  output logic [LEN_W-1:0] length,
  output logic             full,
  output logic             recording
);

  localparam int ADDR_W = $clog2(MAX_NOTES);
  localparam int H_MAX  = 3 * TICK_16;
  localparam int H_W    = $clog2(H_MAX + 1);
  localparam int G_LAST = 2 * TICK_16 - 1;
  localparam int G_W    = (G_LAST > 0) ? $clog2(G_LAST + 1) : 1;
  localparam logic [H_W:0] LIM_16TH = (H_W + 1)'(H_MAX);

  state_t           r_state, w_state_nxt;
  logic             r_rec_en_d;
  logic [2:0]       r_note;
  octave_t          r_oct;
  logic [H_W-1:0]   r_hold;
  logic [G_W-1:0]   r_gap;
  logic [5:0]       r_mem [MAX_NOTES];

  logic [2:0]       w_new_note;
  logic             w_key_active;
  dur_t             w_dur;
  logic [5:0]       w_note_code;
  logic [5:0]       w_append_code;
  logic             w_append, w_append_rest, w_latch, w_hold_inc;
  logic             w_gap_clr, w_gap_inc, w_len_clr, w_wr_en;

  assign w_new_note   = key_to_note(keys);
  assign w_key_active = |keys;

  // Saturated hold count stays at H_MAX, which still classifies as a quarter note.
  always_comb begin
    w_dur = DUR_4TH;
    if ({r_hold, 1'b0} < LIM_16TH)   w_dur = DUR_16TH;
    else if (r_hold < H_W'(H_MAX))    w_dur = DUR_8TH;
  end

  note_encoder u_encoder (
    .note   (r_note),
    .octave (r_oct),
    .dur    (w_dur),
    .code   (w_note_code)
  );

  assign w_append_code = w_append_rest ? REST : w_note_code;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_rec_en_d <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_rec_en_d <= rec_en;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_append      = 1'b0;
    w_append_rest = 1'b0;
    w_latch       = 1'b0;
    w_hold_inc    = 1'b0;
    w_gap_clr     = 1'b0;
    w_gap_inc     = 1'b0;
    w_len_clr     = 1'b0;
    if (!rec_en) begin
      w_append    = (r_state == ST_HOLD);
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!r_rec_en_d) begin
            w_state_nxt = ST_ARMED;
            w_len_clr   = 1'b1;
          end
        end
        ST_ARMED: begin
          if (w_key_active) begin
            w_state_nxt = ST_HOLD;
            w_latch     = 1'b1;
          end
        end
        ST_HOLD: begin
          if (!w_key_active) begin
            w_append    = 1'b1;
            w_gap_clr   = 1'b1;
            w_state_nxt = ST_GAP;
          end else if (w_new_note != r_note) begin
            w_append = 1'b1;
            w_latch  = 1'b1;
          end else begin
            w_hold_inc = 1'b1;
          end
        end
        ST_GAP: begin
          if (w_key_active) begin
            w_state_nxt = ST_HOLD;
            w_latch     = 1'b1;
          end else if (r_gap == G_W'(G_LAST)) begin
            w_append      = 1'b1;
            w_append_rest = 1'b1;
            w_gap_clr     = 1'b1;
          end else begin
            w_gap_inc = 1'b1;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  assign full      = (length == LEN_W'(MAX_NOTES));
  assign recording = (r_state != ST_IDLE);
  assign w_wr_en   = rst_n && w_append && !full;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_note   <= 3'd0;
      r_oct    <= OCT_MID;
      r_hold   <= '0;
      r_gap    <= '0;
      length   <= '0;
      code_vld <= 1'b0;
      code_out <= 6'd0;
    end else begin
      if (w_latch) begin
        r_note <= w_new_note;
        r_oct  <= sel_octave(is_high, is_low);
        r_hold <= H_W'(1);
      end else if (w_hold_inc && (r_hold < H_W'(H_MAX))) begin
        r_hold <= r_hold + H_W'(1);
      end
      if (w_gap_clr)      r_gap <= '0;
      else if (w_gap_inc) r_gap <= r_gap + G_W'(1);
      code_vld <= w_wr_en;
      if (w_wr_en) code_out <= w_append_code;
      if (w_len_clr)    length <= '0;
      else if (w_wr_en) length <= length + LEN_W'(1);
    end
  end

  // Buffer kept free of reset so it maps onto block/distributed RAM.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[length[ADDR_W-1:0]] <= w_append_code;
    if (!rst_n) rd_code <= 6'd0;
    else if (rd_idx < LEN_W'(MAX_NOTES)) rd_code <= r_mem[rd_idx[ADDR_W-1:0]];
  end

endmodule
`default_nettype wire
